if_fetch_unit: RTL and testbench

IF_FETCH_UNIT -- requirements
Module: if_fetch_unit

---
 rtl/sys_defs.sv | 26 ++
 rtl/if_fetch_unit_if.sv | 22 ++
 rtl/fetch_fifo.sv | 58 +++++
 rtl/if_fetch_unit.sv | 131 +++++++++++++
 tb/tb_if_fetch_unit.sv | 322 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sys_defs.sv
// Shared definitions for the fetch front end.
// Contents: NOOP_INST (the bubble instruction), the fetch-state enum, the
// fetch-queue entry layout and the IF/ID register layout.
package sys_defs;

    // addi x0, x0, 0
    localparam logic [31:0] NOOP_INST = 32'h0000_0013;

    typedef enum logic [1:0] {
        FS_RESET_WAIT = 2'd0,
        FS_RUN        = 2'd1,
        FS_DRAIN      = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ir;
    } fetch_entry_t;

    typedef struct packed {
        logic [31:0] ir;
        logic [31:0] pc;
        logic        valid;
    } if_id_t;

endpackage

// File: rtl/if_fetch_unit_if.sv
// Instruction-memory bus between the fetch unit and instruction memory.
// master: fetch side (drives the request, receives the response).
// slave:  memory side.
//   imem_req_valid / imem_req_addr / imem_req_ready : request handshake
//   imem_resp_valid / imem_resp_data                : in-order responses
interface if_fetch_unit_if;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;

    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready, imem_resp_valid, imem_resp_data
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready, imem_resp_valid, imem_resp_data
    );
endinterface

// File: rtl/fetch_fifo.sv
// Generic synchronous FIFO with flush, used as the fetch queue.
// Ports: clk, rst (async, active-high), push/push_data, pop/pop_data
// (pop_data shows the head), flush (empties, wins over push/pop),
// full, empty, count (occupancy). DEPTH must be a power of two.
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    input  logic                     flush,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr, wr_ptr;
    logic             do_push, do_pop;

    assign empty    = (count == '0);
    assign full     = (count == CNT_W'(DEPTH));
    assign do_pop   = pop && !empty;
    // A full queue may still take a push in the same cycle as a pop.
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of every other register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // NOTE: the storage array has no reset; count/pointers alone define
    // which entries are meaningful, so resetting the data would be wasted logic.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: issues word fetches, tracks in-flight requests,
// buffers returned instructions and feeds the IF/ID pipeline register.
// Ports: clk, rst (async, active-high); imem (master side of the
// instruction-memory bus); id_stall (hold IF/ID); redirect_valid/redirect_pc
// (branch/jump target); if_id_IR/PC/NPC/valid_inst (IF/ID register).
module if_fetch_unit
    import sys_defs::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          FQ_DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    if_fetch_unit_if.master        imem,
    input  logic                   id_stall,
    input  logic                   redirect_valid,
    input  logic [31:0]            redirect_pc,
    output logic [31:0]            if_id_IR,
    output logic [31:0]            if_id_PC,
    output logic [31:0]            if_id_NPC,
    output logic                   if_id_valid_inst
);
    localparam int CNT_W = $clog2(FQ_DEPTH) + 1;

    fetch_state_e     state, state_next;
    logic [31:0]      fetch_pc, fetch_pc_next;
    logic [CNT_W-1:0] outstanding, outstanding_next, fq_count;
    if_id_t           if_id, if_id_next;
    fetch_entry_t     fq_head, resp_entry;
    logic             fq_push, fq_pop, fq_flush, fq_full, fq_empty;
    logic             accept, resp_take;

    // Issue only while every in-flight request is guaranteed a queue slot.
    assign imem.imem_req_valid = (state == FS_RUN) &&
                                 ((outstanding + fq_count) < CNT_W'(FQ_DEPTH));
    assign imem.imem_req_addr  = fetch_pc;
    assign accept    = imem.imem_req_valid && imem.imem_req_ready;
    assign resp_take = imem.imem_resp_valid && (outstanding != '0);

    // Requests in RUN are contiguous, so the oldest one sits
    // 4*outstanding bytes behind the fetch PC.
    assign resp_entry = '{pc: fetch_pc - 32'({outstanding, 2'b00}),
                          ir: imem.imem_resp_data};

    fetch_fifo #(
        .DEPTH (FQ_DEPTH),
        .WIDTH ($bits(fetch_entry_t))
    ) u_fetch_queue (
        .clk       (clk),
        .rst       (rst),
        .push      (fq_push),
        .push_data (resp_entry),
        .pop       (fq_pop),
        .flush     (fq_flush),
        .pop_data  (fq_head),
        .full      (fq_full),
        .empty     (fq_empty),
        .count     (fq_count)
    );

    // NOTE: every output of this block gets a default first, so no path
    // leaves a variable unassigned and no latch is inferred.
    always_comb begin
        state_next       = state;
        fetch_pc_next    = fetch_pc;
        if_id_next       = if_id;
        fq_push          = 1'b0;
        fq_pop           = 1'b0;
        fq_flush         = 1'b0;
        outstanding_next = outstanding + CNT_W'(accept) - CNT_W'(resp_take);

        if (accept) fetch_pc_next = fetch_pc + 32'd4;

        if (redirect_valid) begin
            // Anything still in flight, including a request accepted this
            // very cycle, belongs to the old path and must be dropped.
            fq_flush         = 1'b1;
            if_id_next.ir    = NOOP_INST;
            if_id_next.valid = 1'b0;
            fetch_pc_next    = redirect_pc & ~32'h3;
            state_next       = (outstanding_next != '0) ? FS_DRAIN : FS_RUN;
        end else begin
            case (state)
                FS_RESET_WAIT: state_next = FS_RUN;
                FS_RUN: begin
                    if (id_stall) begin
                        fq_push = resp_take && !fq_full;
                    end else if (!fq_empty) begin
                        if_id_next = '{ir: fq_head.ir, pc: fq_head.pc, valid: 1'b1};
                        fq_pop     = 1'b1;
                        fq_push    = resp_take;
                    end else if (resp_take) begin
                        // Bypass the empty queue for single-cycle latency.
                        if_id_next = '{ir: resp_entry.ir, pc: resp_entry.pc, valid: 1'b1};
                    end else begin
                        if_id_next.ir    = NOOP_INST;
                        if_id_next.valid = 1'b0;
                    end
                end
                FS_DRAIN: begin
                    if (!id_stall) begin
                        if_id_next.ir    = NOOP_INST;
                        if_id_next.valid = 1'b0;
                    end
                    if (outstanding_next == '0) state_next = FS_RUN;
                end
                default: state_next = FS_RESET_WAIT;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= FS_RESET_WAIT;
            fetch_pc    <= RESET_PC;
            outstanding <= '0;
            if_id       <= '{ir: NOOP_INST, pc: 32'h0, valid: 1'b0};
        end else begin
            state       <= state_next;
            fetch_pc    <= fetch_pc_next;
            outstanding <= outstanding_next;
            if_id       <= if_id_next;
        end
    end

    assign if_id_IR         = if_id.ir;
    assign if_id_PC         = if_id.pc;
    assign if_id_NPC        = if_id.pc + 32'd4;
    assign if_id_valid_inst = if_id.valid;

endmodule

// File: tb/tb_if_fetch_unit.sv
module tb_if_fetch_unit;
    import sys_defs::*;

    localparam int DEPTH   = 2;
    localparam int DEPTH_W = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_stall, redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] ir, pc, npc;
    logic        vld;
    logic [31:0] ir_w, pc_w, npc_w;
    logic        vld_w;

    if_fetch_unit_if imem();
    if_fetch_unit_if imem_w();

    if_fetch_unit #(.RESET_PC(32'h0000_0000), .FQ_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .imem(imem), .id_stall(id_stall),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .if_id_IR(ir), .if_id_PC(pc), .if_id_NPC(npc), .if_id_valid_inst(vld)
    );

    if_fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .FQ_DEPTH(DEPTH_W)) dut_w (
        .clk(clk), .rst(rst), .imem(imem_w), .id_stall(id_stall),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .if_id_IR(ir_w), .if_id_PC(pc_w), .if_id_NPC(npc_w), .if_id_valid_inst(vld_w)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Memory model: in-order queue of accepted requests with due cycles.
    typedef struct { logic [31:0] addr; int due; } pend_t;
    pend_t pend[$];
    int    cyc = 0;
    int    lat_min = 1, lat_max = 1, ready_pct = 100;
    bit    spurious_en = 1'b0;
    bit    last_acc, last_req_valid, last_ready, last_resp_valid;
    logic [31:0] last_req_addr, last_resp_addr;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    // One clock: present response/ready, take the edge, record the handshake.
    // Called and returns at posedge+1.
    task automatic cycle();
        bit          acc_w;
        logic [31:0] addr_w;
        last_resp_valid      = 1'b0;
        last_resp_addr       = '0;
        imem.imem_resp_valid = 1'b0;
        imem.imem_resp_data  = '0;
        if (pend.size() > 0 && pend[0].due <= cyc) begin
            imem.imem_resp_valid = 1'b1;
            imem.imem_resp_data  = mem_word(pend[0].addr);
            last_resp_valid      = 1'b1;
            last_resp_addr       = pend[0].addr;
            void'(pend.pop_front());
        end else if (pend.size() == 0 && spurious_en && $urandom_range(0, 3) == 0) begin
            imem.imem_resp_valid = 1'b1;
            imem.imem_resp_data  = 32'hDEAD_BEEF;
        end
        imem.imem_req_ready = ($urandom_range(0, 99) < ready_pct);
        #1;
        last_req_valid = imem.imem_req_valid;
        last_ready     = imem.imem_req_ready;
        last_req_addr  = imem.imem_req_addr;
        last_acc       = last_req_valid && last_ready;
        acc_w          = imem_w.imem_req_valid && imem_w.imem_req_ready;
        addr_w         = imem_w.imem_req_addr;
        @(posedge clk);
        #1;
        cyc++;
        if (last_acc)
            pend.push_back('{addr: last_req_addr,
                             due: cyc + int'($urandom_range(lat_min, lat_max)) - 1});
        imem_w.imem_resp_valid = acc_w;
        imem_w.imem_resp_data  = mem_word(addr_w);
    endtask

    task automatic init_inputs();
        id_stall               = 1'b0;
        redirect_valid         = 1'b0;
        redirect_pc            = '0;
        imem.imem_req_ready    = 1'b0;
        imem.imem_resp_valid   = 1'b0;
        imem.imem_resp_data    = '0;
        imem_w.imem_req_ready  = 1'b1;
        imem_w.imem_resp_valid = 1'b0;
        imem_w.imem_resp_data  = '0;
        pend.delete();
    endtask

    // Reset both DUTs and the memory models; returns at posedge+1 with rst low.
    task automatic apply_reset();
        rst = 1'b1;
        init_inputs();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic wait_valid(input int max_cycles, output bit found);
        found = 1'b0;
        for (int i = 0; i < max_cycles && !found; i++) begin
            cycle();
            found = vld;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        init_inputs();
        #2;
        n_checks++; if (imem.imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL reset_req_valid got=%b exp=0", imem.imem_req_valid); end
        n_checks++; if (ir !== NOOP_INST) begin n_fail++; $display("FAIL reset_ir got=%h exp=%h", ir, NOOP_INST); end
        n_checks++; if (pc !== 32'h0) begin n_fail++; $display("FAIL reset_pc got=%h exp=0", pc); end
        n_checks++; if (npc !== 32'h4) begin n_fail++; $display("FAIL reset_npc got=%h exp=4", npc); end
        n_checks++; if (vld !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", vld); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        n_checks++; if (imem.imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL reset_wait_no_req got=%b exp=0", imem.imem_req_valid); end
        ready_pct = 100; lat_min = 1; lat_max = 1;
        cycle();
        n_checks++; if (imem.imem_req_valid !== 1'b1 || imem.imem_req_addr !== 32'h0)
            begin n_fail++; $display("FAIL run_first_req got=%b/%h exp=1/00000000", imem.imem_req_valid, imem.imem_req_addr); end
    endtask

    // Continues directly from test_reset (one edge after rst release).
    task automatic test_stream();
        cycle();
        n_checks++; if (vld !== 1'b0) begin n_fail++; $display("FAIL stream_cycle2_valid got=%b exp=0", vld); end
        for (int k = 0; k < 3; k++) begin
            cycle();
            n_checks++;
            if (vld !== 1'b1 || pc !== 32'(4 * k) || ir !== mem_word(32'(4 * k)) || npc !== 32'(4 * k + 4)) begin
                n_fail++;
                $display("FAIL stream_k%0d got v=%b pc=%h ir=%h npc=%h exp pc=%h", k, vld, pc, ir, npc, 32'(4 * k));
            end
        end
    endtask

    task automatic test_stall();
        bit          found = 1'b0;
        logic [31:0] ir0;
        apply_reset();
        ready_pct = 100; lat_min = 1; lat_max = 1;
        for (int i = 0; i < 20 && !found; i++) begin
            cycle();
            found = vld && (pc == 32'h10);
        end
        n_checks++; if (!found) begin n_fail++; $display("FAIL stall_reach_0x10 got=timeout exp=pc 00000010"); end
        ir0 = ir;
        id_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            n_checks++;
            if (ir !== ir0 || pc !== 32'h10 || vld !== 1'b1) begin
                n_fail++; $display("FAIL stall_hold_%0d got ir=%h pc=%h v=%b exp ir=%h pc=00000010 v=1", i, ir, pc, vld, ir0);
            end
            n_checks++; if (pend.size() > DEPTH) begin n_fail++; $display("FAIL stall_outstanding got=%0d exp<=%0d", pend.size(), DEPTH); end
        end
        id_stall = 1'b0;
        cycle();
        n_checks++; if (vld !== 1'b1 || pc !== 32'h14 || ir !== mem_word(32'h14)) begin n_fail++; $display("FAIL stall_release_1 got v=%b pc=%h exp pc=00000014", vld, pc); end
        cycle();
        n_checks++; if (vld !== 1'b1 || pc !== 32'h18 || ir !== mem_word(32'h18)) begin n_fail++; $display("FAIL stall_release_2 got v=%b pc=%h exp pc=00000018", vld, pc); end
    endtask

    task automatic test_redirect();
        bit found = 1'b0;
        int stale = 0;
        apply_reset();
        ready_pct = 100; lat_min = 3; lat_max = 3;
        for (int i = 0; i < 20 && !found; i++) begin
            cycle();
            found = (pend.size() == 2);
        end
        n_checks++; if (!found) begin n_fail++; $display("FAIL redirect_two_outstanding got=%0d exp=2", pend.size()); end
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        cycle();
        redirect_valid = 1'b0;
        if (last_resp_valid && last_resp_addr < 32'h100) stale++;
        n_checks++; if (vld !== 1'b0 || ir !== NOOP_INST) begin n_fail++; $display("FAIL redirect_bubble got v=%b ir=%h exp v=0 ir=%h", vld, ir, NOOP_INST); end
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            cycle();
            if (last_resp_valid && last_resp_addr < 32'h100) stale++;
            found = vld;
        end
        n_checks++; if (!found || pc !== 32'h100 || ir !== mem_word(32'h100))
            begin n_fail++; $display("FAIL redirect_first_valid got found=%b pc=%h exp pc=00000100", found, pc); end
        n_checks++; if (stale != 2) begin n_fail++; $display("FAIL redirect_dropped got=%0d exp=2", stale); end
    endtask

    task automatic test_redirect_stall();
        bit found;
        apply_reset();
        ready_pct = 100; lat_min = 1; lat_max = 1;
        wait_valid(20, found);
        id_stall       = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h203;
        cycle();
        id_stall       = 1'b0;
        redirect_valid = 1'b0;
        n_checks++; if (vld !== 1'b0 || ir !== NOOP_INST) begin n_fail++; $display("FAIL redir_stall_bubble got v=%b ir=%h exp v=0 ir=%h", vld, ir, NOOP_INST); end
        n_checks++; if (imem.imem_req_addr !== 32'h200) begin n_fail++; $display("FAIL redir_stall_fetch_pc got=%h exp=00000200", imem.imem_req_addr); end
        wait_valid(20, found);
        n_checks++; if (!found || pc !== 32'h200) begin n_fail++; $display("FAIL redir_stall_target got found=%b pc=%h exp=00000200", found, pc); end
    endtask

    task automatic test_backpressure();
        bit          found;
        int          bubbles = 0;
        logic [31:0] a0;
        apply_reset();
        ready_pct = 100; lat_min = 1; lat_max = 1;
        wait_valid(20, found);
        a0 = imem.imem_req_addr;
        ready_pct = 0;
        for (int i = 0; i < 4; i++) begin
            cycle();
            n_checks++;
            if (imem.imem_req_addr !== a0 || imem.imem_req_valid !== 1'b1) begin
                n_fail++; $display("FAIL bp_addr_stable_%0d got v=%b addr=%h exp v=1 addr=%h", i, imem.imem_req_valid, imem.imem_req_addr, a0);
            end
            if (!vld) bubbles++;
        end
        n_checks++; if (vld !== 1'b0 || ir !== NOOP_INST) begin n_fail++; $display("FAIL bp_bubble got v=%b ir=%h exp v=0 ir=%h", vld, ir, NOOP_INST); end
        n_checks++; if (bubbles < 1) begin n_fail++; $display("FAIL bp_bubble_count got=%0d exp>=1", bubbles); end
        ready_pct = 100;
        wait_valid(10, found);
        n_checks++; if (!found || pc !== a0) begin n_fail++; $display("FAIL bp_resume got found=%b pc=%h exp=%h", found, pc, a0); end
    endtask

    task automatic test_wrap();
        apply_reset();
        cycle();
        n_checks++; if (imem_w.imem_req_valid !== 1'b1 || imem_w.imem_req_addr !== 32'hFFFF_FFFC)
            begin n_fail++; $display("FAIL wrap_first_req got v=%b addr=%h exp v=1 addr=fffffffc", imem_w.imem_req_valid, imem_w.imem_req_addr); end
        cycle();
        n_checks++; if (imem_w.imem_req_addr !== 32'h0) begin n_fail++; $display("FAIL wrap_next_addr got=%h exp=00000000", imem_w.imem_req_addr); end
        cycle();
        n_checks++; if (vld_w !== 1'b1 || pc_w !== 32'hFFFF_FFFC || npc_w !== 32'h0 || ir_w !== mem_word(32'hFFFF_FFFC))
            begin n_fail++; $display("FAIL wrap_if_id got v=%b pc=%h npc=%h exp v=1 pc=fffffffc npc=00000000", vld_w, pc_w, npc_w); end
    endtask

    // Random stall/redirect/ready/latency against a program-order model:
    // valid instructions must be consecutive words from the last redirect.
    task automatic test_random();
        logic [31:0] exp_pc, p_ir, p_pc, tgt;
        logic        p_vld;
        bit          red, stl;
        int          n_inst = 0;
        apply_reset();
        lat_min = 1; lat_max = 4; ready_pct = 70; spurious_en = 1'b1;
        exp_pc = 32'h0;
        for (int i = 0; i < 800; i++) begin
            if (i == 400) begin
                apply_reset();
                exp_pc = 32'h0;
            end
            p_ir = ir; p_pc = pc; p_vld = vld;
            stl = ($urandom_range(0, 3) == 0);
            red = ($urandom_range(0, 24) == 0);
            tgt = $urandom();
            id_stall = stl; redirect_valid = red; redirect_pc = tgt;
            cycle();
            id_stall = 1'b0; redirect_valid = 1'b0;
            if (red) begin
                n_checks++; if (vld !== 1'b0 || ir !== NOOP_INST) begin n_fail++; $display("FAIL rnd_redirect_bubble i=%0d got v=%b ir=%h", i, vld, ir); end
                n_checks++; if (imem.imem_req_addr !== {tgt[31:2], 2'b00}) begin n_fail++; $display("FAIL rnd_redirect_pc i=%0d got=%h exp=%h", i, imem.imem_req_addr, {tgt[31:2], 2'b00}); end
                exp_pc = {tgt[31:2], 2'b00};
            end else if (stl) begin
                n_checks++; if (ir !== p_ir || pc !== p_pc || vld !== p_vld) begin n_fail++; $display("FAIL rnd_stall_hold i=%0d got ir=%h pc=%h v=%b exp ir=%h pc=%h v=%b", i, ir, pc, vld, p_ir, p_pc, p_vld); end
            end else if (vld) begin
                n_checks++;
                if (pc !== exp_pc || ir !== mem_word(exp_pc) || npc !== exp_pc + 32'd4) begin
                    n_fail++; $display("FAIL rnd_inst i=%0d got pc=%h ir=%h npc=%h exp pc=%h ir=%h", i, pc, ir, npc, exp_pc, mem_word(exp_pc));
                end
                exp_pc = exp_pc + 32'd4;
                n_inst++;
            end else begin
                n_checks++; if (ir !== NOOP_INST) begin n_fail++; $display("FAIL rnd_bubble_ir i=%0d got=%h exp=%h", i, ir, NOOP_INST); end
            end
            if (last_req_valid && !last_ready && !red) begin
                n_checks++; if (imem.imem_req_addr !== last_req_addr) begin n_fail++; $display("FAIL rnd_addr_stable i=%0d got=%h exp=%h", i, imem.imem_req_addr, last_req_addr); end
            end
            n_checks++; if (pend.size() > DEPTH) begin n_fail++; $display("FAIL rnd_outstanding i=%0d got=%0d exp<=%0d", i, pend.size(), DEPTH); end
        end
        spurious_en = 1'b0;
        n_checks++; if (n_inst < 50) begin n_fail++; $display("FAIL rnd_progress got=%0d exp>=50", n_inst); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_redirect_stall();
        test_backpressure();
        test_wrap();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "simulation time limit");
    end

endmodule
